// File: rtl/shared_adder_arbiter_if.sv
// Requester-side bundle for the shared adder: request/operand pairs in, sums, done pulses and grant out.
// Latency: none (wires only). Backpressure: requesters hold req/operands until their done pulse.
// The master modport is the requester side; the slave modport is the arbiter.
interface shared_adder_arbiter_if #(
    parameter int WIDTH = 8
) ();
    logic             req_one;
    logic             req_two;
    logic             req_three;
    logic [WIDTH-1:0] da_one;
    logic [WIDTH-1:0] db_one;
    logic [WIDTH-1:0] da_two;
    logic [WIDTH-1:0] db_two;
    logic [WIDTH-1:0] da_three;
    logic [WIDTH-1:0] db_three;
    logic [WIDTH-1:0] sum_one;
    logic [WIDTH-1:0] sum_two;
    logic [WIDTH-1:0] sum_three;
    logic             done_one;
    logic             done_two;
    logic             done_three;
    logic [1:0]       grant;
    logic             busy;

    modport master (
        output req_one, req_two, req_three,
        output da_one, db_one, da_two, db_two, da_three, db_three,
        input  sum_one, sum_two, sum_three,
        input  done_one, done_two, done_three,
        input  grant, busy
    );

    modport slave (
        input  req_one, req_two, req_three,
        input  da_one, db_one, da_two, db_two, da_three, db_three,
        output sum_one, sum_two, sum_three,
        output done_one, done_two, done_three,
        output grant, busy
    );
endinterface

// File: rtl/shared_adder_arbiter.sv
// Three requesters share one WIDTH-bit adder through a round-robin IDLE/CALC/DONE sequencer.
// Latency: request sampled at edge k -> sum/done visible after edge k+1; one add per 3 cycles peak.
// Backpressure: losers simply keep req high; nothing is sampled outside IDLE.
module shared_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shared_adder_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        opa_q, opa_d;
    logic [WIDTH-1:0]        opb_q, opb_d;
    logic [2:0][WIDTH-1:0]   sum_q, sum_d;
    logic [2:0]              done_q, done_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              last_q, last_d;

    logic [2:0]              req;
    logic [1:0]              winner;
    logic [WIDTH-1:0]        da_sel;
    logic [WIDTH-1:0]        db_sel;
    logic [WIDTH-1:0]        add_res;

    assign req = {bus.req_three, bus.req_two, bus.req_one};

    // Search starts at the requester after the last one granted.
    always_comb begin
        winner = 2'd0;
        case (last_q)
            2'd1: begin
                if      (req[1]) winner = 2'd2;
                else if (req[2]) winner = 2'd3;
                else if (req[0]) winner = 2'd1;
            end
            2'd2: begin
                if      (req[2]) winner = 2'd3;
                else if (req[0]) winner = 2'd1;
                else if (req[1]) winner = 2'd2;
            end
            default: begin
                if      (req[0]) winner = 2'd1;
                else if (req[1]) winner = 2'd2;
                else if (req[2]) winner = 2'd3;
            end
        endcase
    end

    always_comb begin
        da_sel = '0;
        db_sel = '0;
        case (winner)
            2'd1: begin
                da_sel = bus.da_one;
                db_sel = bus.db_one;
            end
            2'd2: begin
                da_sel = bus.da_two;
                db_sel = bus.db_two;
            end
            2'd3: begin
                da_sel = bus.da_three;
                db_sel = bus.db_three;
            end
            default: begin
                da_sel = '0;
                db_sel = '0;
            end
        endcase
    end

    // The one and only adder; the carry out is dropped so overflow wraps.
    assign add_res = opa_q + opb_q;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        done_d  = '0;
        grant_d = grant_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (winner != 2'd0) begin
                    opa_d   = da_sel;
                    opb_d   = db_sel;
                    grant_d = winner;
                    last_d  = winner;
                    state_d = CALC;
                end else begin
                    grant_d = 2'd0;
                end
            end
            CALC: begin
                case (grant_q)
                    2'd1: begin
                        sum_d[0]  = add_res;
                        done_d[0] = 1'b1;
                    end
                    2'd2: begin
                        sum_d[1]  = add_res;
                        done_d[1] = 1'b1;
                    end
                    2'd3: begin
                        sum_d[2]  = add_res;
                        done_d[2] = 1'b1;
                    end
                    default: done_d = '0;
                endcase
                state_d = DONE;
            end
            DONE: begin
                grant_d = 2'd0;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Pointer resets to "three" so requester one wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            done_q  <= '0;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign bus.sum_one    = sum_q[0];
    assign bus.sum_two    = sum_q[1];
    assign bus.sum_three  = sum_q[2];
    assign bus.done_one   = done_q[0];
    assign bus.done_two   = done_q[1];
    assign bus.done_three = done_q[2];
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter: hand-computed sums, grant order and pulse timing.
module tb_shared_adder_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    shared_adder_arbiter_if #(.WIDTH(8)) bus ();

    shared_adder_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_one = 1'b0; bus.req_two = 1'b0; bus.req_three = 1'b0;
        bus.da_one = 8'd0; bus.db_one = 8'd0;
        bus.da_two = 8'd0; bus.db_two = 8'd0;
        bus.da_three = 8'd0; bus.db_three = 8'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if ({bus.sum_one, bus.sum_two, bus.sum_three} !== 24'd0) begin failures++; $display("FAIL reset_sums got=%0d/%0d/%0d exp=0/0/0", bus.sum_one, bus.sum_two, bus.sum_three); end
        checks++; if ({bus.done_one, bus.done_two, bus.done_three} !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", {bus.done_one, bus.done_two, bus.done_three}); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.req_two = 1'b1; bus.da_two = 8'd100; bus.db_two = 8'd27;
        tick();
        checks++; if (bus.grant !== 2'd2) begin failures++; $display("FAIL single_grant_calc got=%0d exp=2", bus.grant); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", bus.busy); end
        checks++; if (bus.done_two !== 1'b0) begin failures++; $display("FAIL single_done_early got=%0b exp=0", bus.done_two); end
        tick();
        checks++; if (bus.done_two !== 1'b1) begin failures++; $display("FAIL single_done got=%0b exp=1", bus.done_two); end
        checks++; if (bus.sum_two !== 8'd127) begin failures++; $display("FAIL single_sum got=%0d exp=127", bus.sum_two); end
        checks++; if (bus.grant !== 2'd2) begin failures++; $display("FAIL single_grant_done got=%0d exp=2", bus.grant); end
        bus.req_two = 1'b0;
        tick();
        checks++; if (bus.done_two !== 1'b0) begin failures++; $display("FAIL single_done_clear got=%0b exp=0", bus.done_two); end
        checks++; if (bus.grant !== 2'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle got=grant%0d busy%0b exp=grant0 busy0", bus.grant, bus.busy); end
        checks++; if (bus.sum_one !== 8'd0 || bus.sum_three !== 8'd0) begin failures++; $display("FAIL single_others got=%0d/%0d exp=0/0", bus.sum_one, bus.sum_three); end
        checks++; if (bus.sum_two !== 8'd127) begin failures++; $display("FAIL single_sum_hold got=%0d exp=127", bus.sum_two); end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        bus.req_one = 1'b1; bus.da_one = 8'd200; bus.db_one = 8'd100;
        tick();
        checks++; if (bus.grant !== 2'd1) begin failures++; $display("FAIL wrap_grant got=%0d exp=1", bus.grant); end
        tick();
        checks++; if (bus.sum_one !== 8'd44) begin failures++; $display("FAIL wrap_sum got=%0d exp=44", bus.sum_one); end
        bus.req_one = 1'b0;
        if (bus.done_one === 1'b1) pulses++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done_one === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL wrap_pulses got=%0d exp=1", pulses); end
        checks++; if (bus.sum_two !== 8'd127) begin failures++; $display("FAIL wrap_sum_two_hold got=%0d exp=127", bus.sum_two); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_id;
        logic [7:0] exp_sum [3];
        logic [7:0] got_sum;
        logic       got_done;
        bus.da_one = 8'd1;     bus.db_one = 8'd2;
        bus.da_two = 8'd10;    bus.db_two = 8'd20;
        bus.da_three = 8'd250; bus.db_three = 8'd10;
        exp_sum[0] = 8'd3; exp_sum[1] = 8'd30; exp_sum[2] = 8'd4;
        rst_n = 1'b0;
        bus.req_one = 1'b1; bus.req_two = 1'b1; bus.req_three = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 3; i++) begin
                exp_id = 2'(i + 1);
                tick();
                checks++; if (bus.grant !== exp_id) begin failures++; $display("FAIL contention_grant round=%0d got=%0d exp=%0d", round, bus.grant, exp_id); end
                tick();
                got_sum  = (i == 0) ? bus.sum_one  : (i == 1) ? bus.sum_two  : bus.sum_three;
                got_done = (i == 0) ? bus.done_one : (i == 1) ? bus.done_two : bus.done_three;
                checks++; if (got_done !== 1'b1 || got_sum !== exp_sum[i]) begin failures++; $display("FAIL contention_result round=%0d id=%0d got=done%0b sum%0d exp=done1 sum%0d", round, exp_id, got_done, got_sum, exp_sum[i]); end
                if (i == 0) bus.req_one = 1'b0;
                else if (i == 1) bus.req_two = 1'b0;
                else bus.req_three = 1'b0;
                tick();
                checks++; if (bus.grant !== 2'd0) begin failures++; $display("FAIL contention_gap round=%0d got=%0d exp=0", round, bus.grant); end
            end
            bus.da_one = 8'd7;  bus.db_one = 8'd8;
            bus.da_two = 8'd128; bus.db_two = 8'd128;
            bus.da_three = 8'd33; bus.db_three = 8'd44;
            exp_sum[0] = 8'd15; exp_sum[1] = 8'd0; exp_sum[2] = 8'd77;
            bus.req_one = 1'b1; bus.req_two = 1'b1; bus.req_three = 1'b1;
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_seq [4];
        logic [1:0] prev;
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd1; exp_seq[3] = 2'd3;
        prev = 2'd0;
        bus.req_one = 1'b1; bus.da_one = 8'd4; bus.db_one = 8'd4;
        bus.req_three = 1'b1; bus.da_three = 8'd9; bus.db_three = 8'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.grant !== exp_seq[i]) begin failures++; $display("FAIL fairness_grant n=%0d got=%0d exp=%0d", i, bus.grant, exp_seq[i]); end
            checks++; if (prev == 2'd1 && bus.grant === 2'd1) begin failures++; $display("FAIL fairness_repeat n=%0d got=1 exp=3", i); end
            prev = bus.grant;
            tick();
            tick();
        end
        bus.req_one = 1'b0; bus.req_three = 1'b0;
        checks++; if (bus.sum_one !== 8'd8 || bus.sum_three !== 8'd18) begin failures++; $display("FAIL fairness_sums got=%0d/%0d exp=8/18", bus.sum_one, bus.sum_three); end
        tick();
        clear_inputs();
    endtask

    task automatic test_operand_hold();
        bus.req_one = 1'b1; bus.da_one = 8'd5; bus.db_one = 8'd1;
        tick();
        checks++; if (bus.grant !== 2'd1) begin failures++; $display("FAIL hold_grant got=%0d exp=1", bus.grant); end
        bus.da_one = 8'd9;
        tick();
        checks++; if (bus.sum_one !== 8'd6 || bus.done_one !== 1'b1) begin failures++; $display("FAIL hold_sum got=sum%0d done%0b exp=sum6 done1", bus.sum_one, bus.done_one); end
        bus.req_one = 1'b0;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        bus.req_two = 1'b1; bus.da_two = 8'd40; bus.db_two = 8'd2;
        tick();
        checks++; if (bus.grant !== 2'd2) begin failures++; $display("FAIL midrst_grant got=%0d exp=2", bus.grant); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 2'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_force got=grant%0d busy%0b exp=grant0 busy0", bus.grant, bus.busy); end
        checks++; if ({bus.sum_one, bus.sum_two, bus.sum_three} !== 24'd0) begin failures++; $display("FAIL midrst_sums got=%0d/%0d/%0d exp=0/0/0", bus.sum_one, bus.sum_two, bus.sum_three); end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.done_two === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_done got=%0d pulses exp=0", pulses); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.grant !== 2'd2) begin failures++; $display("FAIL midrst_regrant got=%0d exp=2", bus.grant); end
        tick();
        checks++; if (bus.sum_two !== 8'd42 || bus.done_two !== 1'b1) begin failures++; $display("FAIL midrst_sum got=sum%0d done%0b exp=sum42 done1", bus.sum_two, bus.done_two); end
        bus.req_two = 1'b0;
        tick();
        checks++; if (bus.grant !== 2'd0 || bus.done_two !== 1'b0) begin failures++; $display("FAIL midrst_end got=grant%0d done%0b exp=grant0 done0", bus.grant, bus.done_two); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_fairness();
        test_operand_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
